// File: rtl/sl_pkg.sv
// Shared definitions for the SL transmitter: config field layout, reset config,
// default bit timing and FSM state encoding.
package sl_pkg;

    localparam int PCE  = 0;
    localparam int BQL  = 1;
    localparam int BQH  = 6;
    localparam int MODE = 7;
    localparam int IRQM = 8;

    localparam logic [15:0] CFG_RESET = 16'h0010;

    localparam int LOW_CYCLES_DEF  = 8;
    localparam int HIGH_CYCLES_DEF = 8;
    localparam int GAP_CYCLES_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BIT_LOW,
        ST_BIT_HIGH,
        ST_STOP_LOW,
        ST_GAP
    } sl_tx_state_e;

    // Word length must be even and within 8..32 bits.
    function automatic logic bq_legal(input logic [5:0] bq);
        return !bq[0] && (bq >= 6'd8) && (bq <= 6'd32);
    endfunction

endpackage

// File: rtl/sl_tx_shifter.sv
// Word holder for the SL transmitter: latches the masked word, computes odd
// parity and presents the next bit to send plus a bits-remaining flag.
module sl_tx_shifter
    import sl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        advance_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  bq_i,
    input  logic        inj_i,
    output logic        nxt_bit_o,
    output logic        more_o
);

    logic [31:0] word_q;
    logic [31:0] mask_w;
    logic [5:0]  bq_q;
    logic [5:0]  idx_q;
    logic [5:0]  nxt_idx_w;
    logic        inj_q;
    logic        parity_w;

    assign mask_w = (bq_i >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << bq_i) - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 6'd0;
            bq_q  <= 6'd8;
            inj_q <= 1'b0;
        end else if (load_i) begin
            idx_q <= 6'd0;
            bq_q  <= bq_i;
            inj_q <= inj_i;
        end else if (advance_i) begin
            idx_q <= nxt_idx_w;
        end
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            word_q <= data_i & mask_w;
        end
    end

    // Bit 0 is driven straight from the input word at accept, so this side only
    // ever has to look one bit ahead of the bit currently on the line.
    assign nxt_idx_w = idx_q + 6'd1;
    assign parity_w  = ~(^word_q) ^ inj_q;
    assign nxt_bit_o = (nxt_idx_w == bq_q) ? parity_w : word_q[nxt_idx_w[4:0]];
    assign more_o    = nxt_idx_w < (bq_q + 6'd1);

endmodule

// File: rtl/sl_transmitter.sv
// SL word transmitter: serialises BQ data bits, odd parity and a stop pulse onto
// the zeroes/ones lines. `define SL_TX_PARITY_INJECT_EN adds err_inject.
module sl_transmitter
    import sl_pkg::*;
#(
    parameter int CONFIG_WIDTH = 16,
    parameter int LOW_CYCLES   = LOW_CYCLES_DEF,
    parameter int HIGH_CYCLES  = HIGH_CYCLES_DEF,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CONFIG_WIDTH-1:0] wr_config_w,
    input  logic                    wr_enable,
    output logic [CONFIG_WIDTH-1:0] r_config_w,
    input  logic [31:0]             tx_data,
    input  logic                    tx_valid,
`ifdef SL_TX_PARITY_INJECT_EN
    input  logic                    err_inject,
`endif
    output logic                    tx_ready,
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic                    sl_zeroes_o,
    output logic                    sl_ones_o
);

    localparam int MAX_LH = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
    localparam int MAX_C  = (MAX_LH > GAP_CYCLES) ? MAX_LH : GAP_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] LOW_LD  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);

    sl_tx_state_e            state_q;
    logic [CNT_W-1:0]        cyc_q;
    logic [CONFIG_WIDTH-1:0] cfg_q;
    logic [CONFIG_WIDTH-1:0] cfg_d;
    logic                    zero_q, one_q, done_q, ready_q;
    logic                    accept_w, cfg_ok_w, advance_w, inj_w;
    logic                    nxt_bit_w, more_w;

`ifdef SL_TX_PARITY_INJECT_EN
    assign inj_w = err_inject;
`else
    assign inj_w = 1'b0;
`endif

    // A write in the same cycle as an accept takes effect first, so the
    // shifter is loaded with the BQ from cfg_d rather than cfg_q.
    assign cfg_ok_w  = wr_enable && (state_q == ST_IDLE) && bq_legal(wr_config_w[BQH:BQL]);
    assign cfg_d     = cfg_ok_w ? wr_config_w : cfg_q;
    assign accept_w  = tx_valid && ready_q;
    assign advance_w = (state_q == ST_BIT_HIGH) && (cyc_q == '0) && more_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= CONFIG_WIDTH'(CFG_RESET);
        end else begin
            cfg_q <= cfg_d;
        end
    end

    sl_tx_shifter u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (accept_w),
        .advance_i (advance_w),
        .data_i    (tx_data),
        .bq_i      (cfg_d[BQH:BQL]),
        .inj_i     (inj_w),
        .nxt_bit_o (nxt_bit_w),
        .more_o    (more_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            zero_q  <= 1'b1;
            one_q   <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_w) begin
                        state_q <= ST_BIT_LOW;
                        cyc_q   <= LOW_LD;
                        zero_q  <= tx_data[0];
                        one_q   <= ~tx_data[0];
                        ready_q <= 1'b0;
                    end
                end
                ST_BIT_LOW: begin
                    if (cyc_q == '0) begin
                        state_q <= ST_BIT_HIGH;
                        cyc_q   <= HIGH_LD;
                        zero_q  <= 1'b1;
                        one_q   <= 1'b1;
                    end else begin
                        cyc_q <= cyc_q - 1'b1;
                    end
                end
                ST_BIT_HIGH: begin
                    if (cyc_q == '0) begin
                        cyc_q <= LOW_LD;
                        if (more_w) begin
                            state_q <= ST_BIT_LOW;
                            zero_q  <= nxt_bit_w;
                            one_q   <= ~nxt_bit_w;
                        end else begin
                            state_q <= ST_STOP_LOW;
                            zero_q  <= 1'b0;
                            one_q   <= 1'b0;
                        end
                    end else begin
                        cyc_q <= cyc_q - 1'b1;
                    end
                end
                ST_STOP_LOW: begin
                    if (cyc_q == '0) begin
                        state_q <= ST_GAP;
                        cyc_q   <= GAP_LD;
                        zero_q  <= 1'b1;
                        one_q   <= 1'b1;
                    end else begin
                        cyc_q <= cyc_q - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cyc_q == '0) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        cyc_q  <= cyc_q - 1'b1;
                        done_q <= (cyc_q == CNT_W'(1));
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign r_config_w  = cfg_q;
    assign tx_ready    = ready_q;
    assign tx_busy     = ~ready_q;
    assign tx_done     = done_q;
    assign sl_zeroes_o = zero_q;
    assign sl_ones_o   = one_q;

endmodule
